// File: rtl/matrix_ops_pkg.sv
// -----------------------------------------------------------------------------
// matrix_ops_pkg
// Shared definitions for the integer matrix-sum unit and its result drain.
//   MATRIX_DATA_WIDTH : default element width shared by sum unit and drain
//   ST_*_ENC          : drain FSM state encodings
//   drain_state_e     : drain FSM state type built from those encodings
//   clogb2()          : ceiling log2, used for pointer / counter sizing
// -----------------------------------------------------------------------------
package matrix_ops_pkg;

  localparam int MATRIX_DATA_WIDTH = 16;

  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_DRAIN_ENC = 2'd1;
  localparam logic [1:0] ST_FLUSH_ENC = 2'd2;
  localparam logic [1:0] ST_CSUM_ENC  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_DRAIN = ST_DRAIN_ENC,
    ST_FLUSH = ST_FLUSH_ENC,
    ST_CSUM  = ST_CSUM_ENC
  } drain_state_e;

  // Smallest r such that 2**r >= value (returns 0 for value <= 1).
  function automatic int clogb2(input int value);
    int r;
    r = 0;
    while ((32'sd1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/matrix_drain_fifo.sv
// -----------------------------------------------------------------------------
// matrix_drain_fifo
// Synchronous FIFO of {last, data} entries with a combinational head.
//   i_clk, i_rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   i_wr_en        : write request; accepted when not full, or when full and a
//                    read happens in the same cycle
//   i_wr_data      : {last, data} entry to store
//   i_rd_en        : pop the head entry (ignored when empty)
//   o_head         : current head entry, combinational from storage
//   o_count        : number of stored entries (0..DEPTH)
//   o_full/o_empty : occupancy flags
// -----------------------------------------------------------------------------
module matrix_drain_fifo
  import matrix_ops_pkg::*;
#(
  parameter int DATA_WIDTH = MATRIX_DATA_WIDTH,
  parameter int DEPTH      = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_wr_en,
  input  logic [DATA_WIDTH:0]       i_wr_data,
  input  logic                      i_rd_en,
  output logic [DATA_WIDTH:0]       o_head,
  output logic [clogb2(DEPTH):0]    o_count,
  output logic                      o_full,
  output logic                      o_empty
);

  localparam int PW = clogb2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1'b1);
  localparam logic [PW:0]   CNT_ONE   = (PW + 1)'(1'b1);
  localparam logic [PW:0]   DEPTH_CNT = (PW + 1)'(DEPTH);

  logic [DATA_WIDTH:0] mem_r [DEPTH];
  logic [PW-1:0]       wr_ptr_r;
  logic [PW-1:0]       rd_ptr_r;
  logic [PW:0]         count_r;
  logic                wr_s;
  logic                rd_s;

  assign o_full  = (count_r == DEPTH_CNT);
  assign o_empty = (count_r == {(PW + 1){1'b0}});
  assign o_count = count_r;
  assign o_head  = mem_r[rd_ptr_r];

  // A write into a full FIFO is legal only when the head leaves in the same cycle.
  assign rd_s = i_rd_en && !o_empty;
  assign wr_s = i_wr_en && (!o_full || rd_s);

  // Storage array; contents need no reset because occupancy is tracked by count_r.
  always_ff @(posedge i_clk) begin
    if (wr_s) begin
      mem_r[wr_ptr_r] <= i_wr_data;
    end
  end

  // Pointers (wrap modulo DEPTH) and occupancy counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {(PW + 1){1'b0}};
    end else begin
      if (wr_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rd_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({wr_s, rd_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/matrix_result_drain.sv
// -----------------------------------------------------------------------------
// matrix_result_drain
// Pops result elements from the matrix-sum unit and streams them out on a
// valid/ready interface, flagging the final element of each frame with last.
// Optional build macro: MATRIX_DRAIN_CHECKSUM_EN appends a modulo-2^DATA_WIDTH
// checksum word after the data elements; last then moves to that word.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_res_avail    : sum unit has results pending
//   i_up_ready     : sum unit idle and accepting pops
//   i_up_data      : sum unit output register, valid the cycle after a pop
//   o_up_pop       : single-cycle pop strobe to the sum unit
//   o_m_data/o_m_valid/o_m_last/i_m_ready : output stream
//   o_busy         : frame in progress
//   o_elem_count   : data elements captured in the current or last frame
// -----------------------------------------------------------------------------
module matrix_result_drain
  import matrix_ops_pkg::*;
#(
  parameter int DATA_WIDTH = MATRIX_DATA_WIDTH,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_res_avail,
  input  logic                  i_up_ready,
  input  logic [DATA_WIDTH-1:0] i_up_data,
  output logic                  o_up_pop,
  output logic [DATA_WIDTH-1:0] o_m_data,
  output logic                  o_m_valid,
  output logic                  o_m_last,
  input  logic                  i_m_ready,
  output logic                  o_busy,
  output logic [CNT_WIDTH-1:0]  o_elem_count
);

  localparam int PW = clogb2(FIFO_DEPTH);
  localparam logic [PW:0]          DEPTH_CNT = (PW + 1)'(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1'b1);

  drain_state_e           state_r;
  drain_state_e           state_s;
  logic                   pop_s;
  logic                   pop_d1_r;
  logic                   wr_en_s;
  logic [DATA_WIDTH:0]    wr_data_s;
  logic                   data_wr_s;
  logic                   clr_s;
  logic                   rd_en_s;
  logic [DATA_WIDTH:0]    head_s;
  logic [PW:0]            fifo_count_s;
  logic [PW:0]            inflight_s;
  logic                   fifo_full_s;
  logic                   fifo_empty_s;
  logic [CNT_WIDTH-1:0]   elem_count_r;
`ifdef MATRIX_DRAIN_CHECKSUM_EN
  logic [DATA_WIDTH-1:0]  csum_r;
`endif

  matrix_drain_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_wr_en   (wr_en_s),
    .i_wr_data (wr_data_s),
    .i_rd_en   (rd_en_s),
    .o_head    (head_s),
    .o_count   (fifo_count_s),
    .o_full    (fifo_full_s),
    .o_empty   (fifo_empty_s)
  );

  // Occupancy including the element already popped but not yet captured;
  // keeping this below FIFO_DEPTH reserves a slot for every in-flight element.
  assign inflight_s = fifo_count_s + {{PW{1'b0}}, pop_d1_r};

  assign rd_en_s      = o_m_valid && i_m_ready;
  assign o_m_valid    = !fifo_empty_s;
  // Gate the head so the stream reads zero whenever nothing is valid.
  assign o_m_data     = fifo_empty_s ? {DATA_WIDTH{1'b0}} : head_s[DATA_WIDTH-1:0];
  assign o_m_last     = !fifo_empty_s && head_s[DATA_WIDTH];
  assign o_up_pop     = pop_s;
  assign o_busy       = (state_r != ST_IDLE);
  assign o_elem_count = elem_count_r;

  // Next-state, pop strobe and FIFO write selection.
  always_comb begin
    state_s   = state_r;
    pop_s     = 1'b0;
    wr_en_s   = 1'b0;
    wr_data_s = {(DATA_WIDTH + 1){1'b0}};
    data_wr_s = 1'b0;
    clr_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_res_avail && i_up_ready) begin
          state_s = ST_DRAIN;
          clr_s   = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        pop_s = i_res_avail && i_up_ready && !fifo_full_s && (inflight_s < DEPTH_CNT);
        if (pop_d1_r) begin
          // The sum unit drops res_avail the cycle after its final pop, so a
          // capture with res_avail low is the last element of the frame.
          wr_en_s   = 1'b1;
          data_wr_s = 1'b1;
`ifdef MATRIX_DRAIN_CHECKSUM_EN
          wr_data_s = {1'b0, i_up_data};
          if (!i_res_avail) begin
            state_s = ST_CSUM;
          end else begin
            state_s = ST_DRAIN;
          end
`else
          wr_data_s = {!i_res_avail, i_up_data};
          if (!i_res_avail) begin
            state_s = ST_FLUSH;
          end else begin
            state_s = ST_DRAIN;
          end
`endif
        end else if (!i_res_avail) begin
          // Upstream abandoned the frame with nothing in flight: no last flag.
          state_s = ST_FLUSH;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_FLUSH: begin
        if (fifo_empty_s && !pop_d1_r) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_FLUSH;
        end
      end
`ifdef MATRIX_DRAIN_CHECKSUM_EN
      ST_CSUM: begin
        if (!fifo_full_s || rd_en_s) begin
          wr_en_s   = 1'b1;
          wr_data_s = {1'b1, csum_r};
          state_s   = ST_FLUSH;
        end else begin
          state_s = ST_CSUM;
        end
      end
`endif
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state and one-cycle delayed pop (marks when i_up_data is valid).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r  <= ST_IDLE;
      pop_d1_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      pop_d1_r <= pop_s;
    end
  end

  // Per-frame captured element counter, saturating at all-ones.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      elem_count_r <= {CNT_WIDTH{1'b0}};
    end else if (clr_s) begin
      elem_count_r <= {CNT_WIDTH{1'b0}};
    end else if (data_wr_s && (elem_count_r != CNT_MAX)) begin
      elem_count_r <= elem_count_r + CNT_ONE;
    end else begin
      elem_count_r <= elem_count_r;
    end
  end

`ifdef MATRIX_DRAIN_CHECKSUM_EN
  // Running modulo-2^DATA_WIDTH sum of the data elements of the frame.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      csum_r <= {DATA_WIDTH{1'b0}};
    end else if (clr_s) begin
      csum_r <= {DATA_WIDTH{1'b0}};
    end else if (data_wr_s) begin
      csum_r <= csum_r + i_up_data;
    end else begin
      csum_r <= csum_r;
    end
  end
`endif

endmodule

// File: tb/tb_matrix_result_drain.sv
// -----------------------------------------------------------------------------
// tb_matrix_result_drain
// Directed and randomized frames through matrix_result_drain. A simple sum-unit
// model feeds pops; the expected stream is the frame list itself (plus the
// checksum word when MATRIX_DRAIN_CHECKSUM_EN is defined).
// -----------------------------------------------------------------------------
module tb_matrix_result_drain;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int CW    = 16;
`ifdef MATRIX_DRAIN_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  logic          clk;
  logic          rst_n;
  logic          res_avail;
  logic          up_ready;
  logic [DW-1:0] up_data;
  logic          up_pop;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_last;
  logic          m_ready;
  logic          busy;
  logic [CW-1:0] elem_count;

  matrix_result_drain #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .CNT_WIDTH  (CW)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_res_avail  (res_avail),
    .i_up_ready   (up_ready),
    .i_up_data    (up_data),
    .o_up_pop     (up_pop),
    .o_m_data     (m_data),
    .o_m_valid    (m_valid),
    .o_m_last     (m_last),
    .i_m_ready    (m_ready),
    .o_busy       (busy),
    .o_elem_count (elem_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] frame_q[$];
  beat_t         exp_q[$];
  int            cyc, pops, early_pops, extra, up_idx, up_rem;
  int            first_pop_cyc, first_valid_cyc;
  logic          prev_valid, prev_ready, prev_last;
  logic [DW-1:0] prev_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected stream: every element in order, last on the final one, or a
  // trailing modulo-65536 sum word carrying last when the checksum is built in.
  task automatic build_expected();
    int    sum;
    beat_t b;
    sum = 0;
    exp_q.delete();
    for (int i = 0; i < frame_q.size(); i++) begin
      sum    = (sum + int'(frame_q[i])) % 65536;
      b.data = frame_q[i];
      b.last = (i == frame_q.size() - 1) && !CSUM_EN;
      exp_q.push_back(b);
    end
    if (CSUM_EN) begin
      b.data = sum[DW-1:0];
      b.last = 1'b1;
      exp_q.push_back(b);
    end
  endtask

  task automatic set_ready(input int mode);
    case (mode)
      0:       m_ready = 1'b1;
      1:       m_ready = (cyc >= 30);
      2:       m_ready = 1'($urandom_range(0, 1));
      default: m_ready = 1'b1;
    endcase
  endtask

  // One clock: observe at the falling edge, then update the sum-unit model
  // just after the rising edge at which a pop took effect.
  task automatic step(input int mode);
    logic  pop_seen;
    beat_t b;
    @(negedge clk);
    cyc++;
    pop_seen = up_pop;
    if (pop_seen) begin
      pops++;
      if (cyc < 30) early_pops++;
      if (first_pop_cyc < 0) first_pop_cyc = cyc;
    end
    if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (prev_valid && !prev_ready) begin
      chk("hold_valid", m_valid, 1);
      chk("hold_data", m_data, prev_data);
      chk("hold_last", m_last, prev_last);
    end
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        extra++;
      end else begin
        b = exp_q.pop_front();
        chk("beat_data", m_data, b.data);
        chk("beat_last", m_last, b.last);
      end
    end
    prev_valid = m_valid;
    prev_ready = m_ready;
    prev_data  = m_data;
    prev_last  = m_last;
    @(posedge clk);
    #1;
    if (pop_seen && up_rem > 0) begin
      up_data = frame_q[up_idx];
      up_idx++;
      up_rem--;
      res_avail = (up_rem != 0);
    end
    set_ready(mode);
  endtask

  task automatic start_frame(input int mode);
    build_expected();
    cyc = 0; pops = 0; early_pops = 0; extra = 0;
    first_pop_cyc = -1; first_valid_cyc = -1;
    prev_valid = 1'b0; prev_ready = 1'b1;
    up_idx = 0; up_rem = frame_q.size();
    res_avail = 1'b1;
    up_ready  = 1'b1;
    set_ready(mode);
  endtask

  task automatic run_frame(input string name, input int mode);
    int done;
    start_frame(mode);
    done = 0;
    for (int k = 0; k < 3000 && done == 0; k++) begin
      step(mode);
      if (exp_q.size() == 0 && !busy && !m_valid) done = 1;
    end
    chk({name, "/done"}, done, 1);
    chk({name, "/pops"}, pops, frame_q.size());
    chk({name, "/elem_count"}, elem_count, frame_q.size());
    chk({name, "/extra_beats"}, extra, 0);
    chk({name, "/latency"}, first_valid_cyc - first_pop_cyc, 2);
    if (mode == 1) chk({name, "/stall_pops"}, early_pops, DEPTH);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; res_avail = 1'b0; up_ready = 1'b1; up_data = 16'h0000; m_ready = 1'b1;
    #12;
    chk("rst/pop", up_pop, 0);
    chk("rst/valid", m_valid, 0);
    chk("rst/last", m_last, 0);
    chk("rst/data", m_data, 0);
    chk("rst/busy", busy, 0);
    chk("rst/count", elem_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    frame_q = '{16'd5, 16'hFFFE, 16'd7};
    run_frame("f3", 0);

    frame_q = '{16'h7FFF};
    run_frame("f1", 0);

    frame_q.delete();
    for (int i = 0; i < 20; i++) frame_q.push_back(16'($urandom));
    run_frame("f20_stall", 1);

    frame_q.delete();
    for (int i = 0; i < 12; i++) frame_q.push_back(16'($urandom));
    run_frame("f12_rand", 2);

    frame_q = '{16'h8000, 16'h8001};
    run_frame("f2_csum", 0);

    frame_q.delete();
    n = 30;
    for (int i = 0; i < n; i++) frame_q.push_back(16'($urandom));
    run_frame("f30_rand", 2);

    // Reset in the middle of a 10-element frame, right after the 4th pop.
    frame_q.delete();
    for (int i = 0; i < 10; i++) frame_q.push_back(16'($urandom) | 16'h0001);
    start_frame(1);
    for (int k = 0; k < 100 && pops < 4; k++) step(1);
    chk("mid/pops", pops, 4);
    chk("mid/valid_before", m_valid, 1);
    #1;
    rst_n = 1'b0;
    // The upstream frame is abandoned too, so the drain must stay idle after release.
    res_avail = 1'b0;
    #1;
    chk("mid/pop", up_pop, 0);
    chk("mid/valid", m_valid, 0);
    chk("mid/last", m_last, 0);
    chk("mid/data", m_data, 0);
    chk("mid/busy", busy, 0);
    chk("mid/count", elem_count, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    prev_valid = 1'b0;
    extra = 0;
    for (int k = 0; k < 4; k++) step(0);
    chk("mid/idle_busy", busy, 0);
    chk("mid/idle_valid", m_valid, 0);
    chk("mid/idle_count", elem_count, 0);
    chk("mid/no_beats", extra, 0);

    // A fresh frame after the reset drains normally.
    frame_q = '{16'h1234, 16'h00FF, 16'hABCD};
    run_frame("post_rst", 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
